sdram_init_seq: RTL



---
 rtl/sdram_init_seq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/sdram_init_seq.sv
`timescale 1ns/1ps
// SDRAM power-up sequencer: NOP wait, PRECHARGE ALL, N_REF auto-refreshes, LOAD MODE, then init_done.
// Optional macro SDR_INIT_EXT_MRS_EN adds an EXTENDED LOAD MODE after LOAD MODE.
module sdram_init_seq #(
  parameter int unsigned SDR_AW = 13,
  parameter int unsigned SDR_BW = 2,
  parameter int unsigned T_INIT = 500,
  parameter int unsigned T_RP   = 3,
  parameter int unsigned T_RFC  = 7,
  parameter int unsigned N_REF  = 2,
  parameter int unsigned T_MRD  = 2,
`ifdef SDR_INIT_EXT_MRS_EN
  parameter logic [SDR_AW-1:0] EXT_MODE_REG = SDR_AW'(13'h000),
`endif
  parameter logic [SDR_AW-1:0] MODE_REG = SDR_AW'(13'h033)
) (
  input  logic              sdram_clk,
  input  logic              sdram_resetn,
  input  logic              init_req,
  output logic              sdr_cke,
  output logic              sdr_cs_n,
  output logic              sdr_ras_n,
  output logic              sdr_cas_n,
  output logic              sdr_we_n,
  output logic [SDR_AW-1:0] sdr_addr,
  output logic [SDR_BW-1:0] sdr_ba,
  output logic              init_done
);

  localparam int unsigned MAX_A = (T_INIT > T_RP) ? T_INIT : T_RP;
  localparam int unsigned MAX_B = (T_RFC > T_MRD) ? T_RFC : T_MRD;
  localparam int unsigned MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W = $clog2(MAX_T) + 1;
  localparam int unsigned REF_W = $clog2(N_REF + 1);

  // {ras_n, cas_n, we_n}
  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_LMR = 3'b000;

  localparam logic [SDR_AW-1:0] ADDR_A10 = SDR_AW'(1024);

  // Each command is issued on the edge that enters its timing state.
  typedef enum logic [2:0] {
    S_WAIT,
    S_TRP,
    S_TRFC,
    S_TMRD,
`ifdef SDR_INIT_EXT_MRS_EN
    S_TEMRD,
`endif
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [REF_W-1:0] ref_cnt;

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state     <= S_WAIT;
      cnt       <= '0;
      ref_cnt   <= '0;
      sdr_cke   <= 1'b0;
      sdr_cs_n  <= 1'b1;
      {sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_NOP;
      sdr_addr  <= '0;
      sdr_ba    <= '0;
      init_done <= 1'b0;
    end else begin
      sdr_cke   <= 1'b1;
      sdr_cs_n  <= 1'b0;
      {sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_NOP;
      sdr_addr  <= '0;
      sdr_ba    <= '0;
      init_done <= 1'b0;

      case (state)
        // WAIT counts elapsed NOP cycles up from the cleared value
        S_WAIT: begin
          if (cnt == CNT_W'(T_INIT)) begin
            {sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_PRE;
            sdr_addr <= ADDR_A10;
            ref_cnt  <= '0;
            cnt      <= CNT_W'(T_RP - 1);
            state    <= S_TRP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_TRP: begin
          if (cnt == '0) begin
            {sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_REF;
            ref_cnt <= REF_W'(1);
            cnt     <= CNT_W'(T_RFC - 1);
            state   <= S_TRFC;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_TRFC: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (ref_cnt == REF_W'(N_REF)) begin
            {sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_LMR;
            sdr_addr <= MODE_REG;
            cnt      <= CNT_W'(T_MRD - 1);
            state    <= S_TMRD;
          end else begin
            {sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_REF;
            ref_cnt <= ref_cnt + REF_W'(1);
            cnt     <= CNT_W'(T_RFC - 1);
          end
        end

        S_TMRD: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
`ifdef SDR_INIT_EXT_MRS_EN
            {sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_LMR;
            sdr_addr <= EXT_MODE_REG;
            sdr_ba   <= SDR_BW'(2);
            cnt      <= CNT_W'(T_MRD - 1);
            state    <= S_TEMRD;
`else
            sdr_cs_n  <= 1'b1;
            init_done <= 1'b1;
            state     <= S_DONE;
`endif
          end
        end

`ifdef SDR_INIT_EXT_MRS_EN
        S_TEMRD: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            sdr_cs_n  <= 1'b1;
            init_done <= 1'b1;
            state     <= S_DONE;
          end
        end
`endif

        // Bus handed to the controller; a request restarts from WAIT with cke kept high
        S_DONE: begin
          sdr_cs_n <= 1'b1;
          if (init_req) begin
            cnt     <= '0;
            ref_cnt <= '0;
            state   <= S_WAIT;
          end else begin
            init_done <= 1'b1;
          end
        end

        default: begin
          sdr_cs_n <= 1'b1;
          cnt      <= '0;
          ref_cnt  <= '0;
          state    <= S_WAIT;
        end
      endcase
    end
  end

endmodule
